// File: rtl/minus_recovery_serial_pkg.sv
// Shared ALU definitions for the bit-serial two's-complement to sign-magnitude decoder.
package minus_recovery_serial_pkg;

  localparam int ALU_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ALU_WIDTH-1:0] MOST_NEG = {1'b1, {(ALU_WIDTH-1){1'b0}}};

endpackage

// File: rtl/minus_recovery_serial_bit_cell.sv
// One serial step of copy-until-first-one-then-invert: seen_one flag plus the copy/invert mux.
module minus_bit_cell (
  input  logic clk,
  input  logic reset,
  input  logic b,
  input  logic neg,
  input  logic clear,
  input  logic enable,
  output logic out_bit
);

  logic seen_one;

  // The first 1 is copied unchanged; only later bits see the flag set.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      seen_one <= 1'b0;
    end else if (enable && neg && b) begin
      seen_one <= 1'b1;
    end
  end

  assign out_bit = (neg && seen_one) ? ~b : b;

endmodule

// File: rtl/minus_recovery_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, start/busy/done framed.
module minus_recovery_serial
  import minus_recovery_serial_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] X_Minus_in,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] magnitude,
  output logic             min_neg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t state, state_next;
  logic accept, step, last;
  logic [WIDTH-1:0] shreg, result, result_next;
  logic [CW-1:0] count;
  logic neg, low_zero, out_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (count == LAST_COUNT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  minus_bit_cell u_cell (
    .clk     (clk),
    .reset   (reset),
    .b       (shreg[0]),
    .neg     (neg),
    .clear   (accept),
    .enable  (step),
    .out_bit (out_bit)
  );

  // Each output bit enters at the MSB so the word is aligned after WIDTH shifts.
  assign result_next = {out_bit, result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      result   <= '0;
      count    <= '0;
      neg      <= 1'b0;
      low_zero <= 1'b0;
    end else if (accept) begin
      shreg    <= X_Minus_in;
      result   <= '0;
      count    <= '0;
      neg      <= X_Minus_in[WIDTH-1];
      low_zero <= (X_Minus_in[WIDTH-2:0] == '0);
    end else if (step) begin
      shreg  <= shreg >> 1;
      result <= result_next;
      count  <= count + CW'(1);
    end
  end

  // Results update only on the final shift, so they hold steady through a conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      sign      <= 1'b0;
      magnitude <= '0;
      min_neg   <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (last) begin
        magnitude <= result_next;
        sign      <= neg;
        min_neg   <= neg & low_zero;
      end
    end
  end

endmodule

// File: tb/tb_minus_recovery_serial.sv
// Self-checking bench for minus_recovery_serial against an arithmetic absolute-value model.
module tb_minus_recovery_serial;
  import minus_recovery_serial_pkg::*;

  localparam int W = ALU_WIDTH;

  logic clk = 1'b0;
  logic reset, start;
  logic [W-1:0] x_minus_in;
  logic busy, done, sign, min_neg;
  logic [W-1:0] magnitude;

  int passed = 0;
  int total  = 0;
  int cycle  = 0;

  minus_recovery_serial #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .X_Minus_in (x_minus_in),
    .busy       (busy),
    .done       (done),
    .sign       (sign),
    .magnitude  (magnitude),
    .min_neg    (min_neg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  function automatic logic [W-1:0] model_mag(input logic [W-1:0] v);
    int s;
    s = int'(v);
    if (v[W-1]) s = s - (1 << W);
    if (s < 0) s = -s;
    return W'(s);
  endfunction

  function automatic logic model_min_neg(input logic [W-1:0] v);
    return (v == MOST_NEG);
  endfunction

  task automatic start_pulse(input logic [W-1:0] v);
    x_minus_in = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called right after the accepting edge; returns done latency and busy-high cycle count.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done && lat < 0) lat = k;
      if (lat >= 0 && !busy) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; x_minus_in = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, sign, min_neg, magnitude} !== '0)
      $display("[TB] FAIL reset_outputs: got %b expected 0", {busy, done, sign, min_neg, magnitude});
    else passed++;
    start = 1'b1; x_minus_in = 6'b111111;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_beats_start: busy got %b expected 0", busy);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_beats_start_idle: busy got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_directed();
    logic [W-1:0] vecs [5];
    int lat, bc;
    vecs = '{6'b111101, 6'b000101, 6'b000000, 6'b100000, 6'b111111};
    foreach (vecs[i]) begin
      start_pulse(vecs[i]);
      x_minus_in = W'($urandom);
      wait_done(lat, bc);
      total++;
      if (lat !== W) $display("[TB] FAIL dir_latency v=%b: got %0d expected %0d", vecs[i], lat, W);
      else passed++;
      total++;
      if (bc !== W + 1) $display("[TB] FAIL dir_busy_cycles v=%b: got %0d expected %0d", vecs[i], bc, W + 1);
      else passed++;
      total++;
      if (done !== 1'b0) $display("[TB] FAIL dir_done_pulse v=%b: got %b expected 0", vecs[i], done);
      else passed++;
      total++;
      if (sign !== vecs[i][W-1]) $display("[TB] FAIL dir_sign v=%b: got %b expected %b", vecs[i], sign, vecs[i][W-1]);
      else passed++;
      total++;
      if (magnitude !== model_mag(vecs[i]))
        $display("[TB] FAIL dir_mag v=%b: got %0d expected %0d", vecs[i], magnitude, model_mag(vecs[i]));
      else passed++;
      total++;
      if (min_neg !== model_min_neg(vecs[i]))
        $display("[TB] FAIL dir_min_neg v=%b: got %b expected %b", vecs[i], min_neg, model_min_neg(vecs[i]));
      else passed++;
    end
  endtask

  task automatic test_hold_outputs();
    int lat, bc;
    logic [W-1:0] v;
    start_pulse(6'b000111);
    wait_done(lat, bc);
    v = 6'b101010;
    start_pulse(v);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({sign, magnitude, min_neg} !== {1'b0, 6'd7, 1'b0})
      $display("[TB] FAIL hold_during_shift: got s=%b m=%0d n=%b expected s=0 m=7 n=0", sign, magnitude, min_neg);
    else passed++;
    wait_done(lat, bc);
    total++;
    if (magnitude !== model_mag(v)) $display("[TB] FAIL hold_final_mag: got %0d expected %0d", magnitude, model_mag(v));
    else passed++;
  endtask

  task automatic test_ignore_start();
    int ndone;
    ndone = 0;
    start_pulse(6'b110110);
    repeat (2) @(posedge clk);
    #1;
    x_minus_in = 6'b000001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (done) ndone++;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    total++;
    if (ndone !== 1) $display("[TB] FAIL ignore_done_count: got %0d expected 1", ndone);
    else passed++;
    total++;
    if (magnitude !== 6'd10) $display("[TB] FAIL ignore_mag: got %0d expected 10", magnitude);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL ignore_busy_idle: got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_start_in_done();
    bit seen;
    seen = 1'b0;
    start_pulse(W'($urandom));
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) $display("[TB] FAIL done_cycle_timeout: got no done expected done");
    else passed++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL done_cycle_start_ignored: busy got %b expected 0", busy);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL done_cycle_not_queued: busy got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid_shift();
    int ndone, lat, bc;
    ndone = 0;
    start_pulse(6'b101011);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({busy, done, sign, min_neg, magnitude} !== '0)
      $display("[TB] FAIL mid_reset_outputs: got %b expected 0", {busy, done, sign, min_neg, magnitude});
    else passed++;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0) $display("[TB] FAIL mid_reset_no_done: got %0d expected 0", ndone);
    else passed++;
    start_pulse(6'b101011);
    wait_done(lat, bc);
    total++;
    if (lat !== W) $display("[TB] FAIL mid_reset_latency: got %0d expected %0d", lat, W);
    else passed++;
    total++;
    if ({sign, magnitude} !== {1'b1, 6'd21})
      $display("[TB] FAIL mid_reset_result: got s=%b m=%0d expected s=1 m=21", sign, magnitude);
    else passed++;
  endtask

  task automatic test_sweep();
    int prev;
    bit seen;
    prev = -1;
    start = 1'b1;
    for (int i = 0; i < (1 << W); i++) begin
      x_minus_in = W'(i);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        if (done) begin seen = 1'b1; break; end
      end
      total++;
      if (!seen) begin
        $display("[TB] FAIL sweep_timeout v=%0d: got no done expected done", i);
        continue;
      end
      passed++;
      total++;
      if ({sign, magnitude, min_neg} !== {x_minus_in[W-1], model_mag(x_minus_in), model_min_neg(x_minus_in)})
        $display("[TB] FAIL sweep_result v=%0d: got s=%b m=%0d n=%b expected s=%b m=%0d n=%b", i, sign, magnitude,
                 min_neg, x_minus_in[W-1], model_mag(x_minus_in), model_min_neg(x_minus_in));
      else passed++;
      if (prev >= 0) begin
        total++;
        if (cycle - prev !== W + 2) $display("[TB] FAIL sweep_period v=%0d: got %0d expected %0d", i, cycle - prev, W + 2);
        else passed++;
      end
      prev = cycle;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int lat, bc;
    for (int n = 0; n < 30; n++) begin
      v = W'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      start_pulse(v);
      x_minus_in = W'($urandom);
      wait_done(lat, bc);
      total++;
      if (lat !== W) $display("[TB] FAIL rand_latency v=%b: got %0d expected %0d", v, lat, W);
      else passed++;
      total++;
      if ({sign, magnitude, min_neg} !== {v[W-1], model_mag(v), model_min_neg(v)})
        $display("[TB] FAIL rand_result v=%b: got s=%b m=%0d n=%b expected s=%b m=%0d n=%b", v, sign, magnitude,
                 min_neg, v[W-1], model_mag(v), model_min_neg(v));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_outputs();
    test_ignore_start();
    test_start_in_done();
    test_reset_mid_shift();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
